// File: rtl/video_buf_pkg.sv
// Shared encodings and helpers for the video read buffer.
package video_buf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_PRE  = 3'b010,
    ST_ADDR = 3'b100
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI arsize encoding: log2 of the bytes per beat.
  function automatic logic [2:0] axi_size(input int data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head entry is always on rd_data.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/video_rd_buffer.sv
// AXI4 read master: queues burst requests, issues credit-gated AR bursts and
// streams the returned beats back through a FWFT data FIFO.
module video_rd_buffer
  import video_buf_pkg::*;
#(
  parameter int  AXI_DATA_WIDTH  = 128,
  parameter int  AXI_ADDR_WIDTH  = 32,
  parameter int  CMD_DEPTH       = 16,
  parameter int  DATA_DEPTH      = 512,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(DATA_DEPTH) + 1,
  localparam int OW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [3:0]                m_axi_arid,
  output logic [1:0]                m_axi_arburst,
  output logic [2:0]                m_axi_arsize,
  output logic [2:0]                m_axi_arprot,
  output logic [3:0]                m_axi_arqos,
  output logic                      m_axi_arlock,
  output logic [3:0]                m_axi_arcache,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic [3:0]                m_axi_rid,
  input  logic                      m_axi_rlast,
  input  logic                      i_rd_buff_req_en,
  input  logic [7:0]                i_rd_buff_burst_len,
  input  logic [AXI_ADDR_WIDTH-1:0] i_rd_buff_addr,
  output logic                      o_rd_cmd_ready,
  output logic                      o_rd_buff_vld,
  output logic [AXI_DATA_WIDTH-1:0] o_rd_buff_data,
  output logic                      o_rd_buff_data_last,
  input  logic                      i_rd_buff_rden,
  output logic                      o_rd_cmd_fifo_err,
  output logic                      o_rd_resp_err,
  output logic [2:0]                o_dbg_state,
  output logic [CW-1:0]             o_dbg_inflight,
  output logic [OW-1:0]             o_dbg_outstanding
);

  localparam int CMD_W = 8 + AXI_ADDR_WIDTH;
  localparam int DAT_W = AXI_DATA_WIDTH + 1;

  rd_state_e                   state, state_nxt;
  logic [CW-1:0]               inflight, free, need, data_count;
  logic [OW-1:0]               outstanding;
  logic                        cmd_full, cmd_empty, cmd_rd;
  logic [CMD_W-1:0]            cmd_head;
  logic [$clog2(CMD_DEPTH):0]  cmd_count_unused;
  logic                        data_full_unused, data_empty;
  logic [DAT_W-1:0]            data_head;
  logic [7:0]                  head_len;
  logic [AXI_ADDR_WIDTH-1:0]   head_addr;
  logic                        ar_hs, r_hs, r_last_hs;
  logic                        unused_sig;

  // Handshakes: a transfer happens on an edge where valid && ready; arvalid
  // never drops before arready and araddr/arlen hold while it is high. rready
  // is tied high because AR issue reserves FIFO space for every beat.
  assign m_axi_rready  = 1'b1;
  assign ar_hs         = m_axi_arvalid && m_axi_arready;
  assign r_hs          = m_axi_rvalid;
  assign r_last_hs     = r_hs && m_axi_rlast;

  assign m_axi_arid    = '0;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arsize  = axi_size(AXI_DATA_WIDTH);
  assign m_axi_arprot  = '0;
  assign m_axi_arqos   = '0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = '0;

  assign {head_len, head_addr} = cmd_head;
  assign cmd_rd = (state == ST_PRE);
  assign free   = CW'(DATA_DEPTH) - data_count - inflight;
  assign need   = CW'(head_len) + 1'b1;

  sync_fifo_fwft #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .wr_en   (i_rd_buff_req_en),
    .wr_data ({i_rd_buff_burst_len, i_rd_buff_addr}),
    .rd_en   (cmd_rd),
    .rd_data (cmd_head),
    .count   (cmd_count_unused),
    .full    (cmd_full),
    .empty   (cmd_empty)
  );

  sync_fifo_fwft #(.WIDTH(DAT_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk     (i_clk),
    .reset   (i_reset),
    .wr_en   (m_axi_rvalid),
    .wr_data ({m_axi_rlast, m_axi_rdata}),
    .rd_en   (i_rd_buff_rden),
    .rd_data (data_head),
    .count   (data_count),
    .full    (data_full_unused),
    .empty   (data_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!cmd_empty && free >= need && outstanding < OW'(MAX_OUTSTANDING))
                 state_nxt = ST_PRE;
      ST_PRE:  state_nxt = ST_ADDR;
      ST_ADDR: if (ar_hs) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // inflight reserves FIFO space at PRE so a later command cannot claim it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= ST_IDLE;
      m_axi_arvalid     <= 1'b0;
      m_axi_araddr      <= '0;
      m_axi_arlen       <= '0;
      inflight          <= '0;
      outstanding       <= '0;
      o_rd_cmd_fifo_err <= 1'b0;
      o_rd_resp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_rd) begin
        m_axi_araddr  <= head_addr;
        m_axi_arlen   <= head_len;
        m_axi_arvalid <= 1'b1;
      end else if (ar_hs) begin
        m_axi_arvalid <= 1'b0;
      end
      inflight <= inflight + (cmd_rd ? need : '0) - (r_hs ? CW'(1) : '0);
      case ({ar_hs, r_last_hs})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase
      if (i_rd_buff_req_en && cmd_full) o_rd_cmd_fifo_err <= 1'b1;
      if (r_hs && m_axi_rresp != AXI_RESP_OKAY) o_rd_resp_err <= 1'b1;
    end
  end

  assign o_rd_cmd_ready                        = !cmd_full;
  assign o_rd_buff_vld                         = !data_empty;
  assign {o_rd_buff_data_last, o_rd_buff_data} = data_head;
  assign o_dbg_state                           = state;
  assign o_dbg_inflight                        = inflight;
  assign o_dbg_outstanding                     = outstanding;
  assign unused_sig = ^{m_axi_rid, cmd_count_unused, data_full_unused};

endmodule

// File: tb/tb_video_rd_buffer.sv
// Directed bench for video_rd_buffer: AXI slave model, request-derived
// scoreboard and a per-cycle output compare against a FIFO-level model.
module tb_video_rd_buffer;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int DEPTH = 512;

  // ---------------- clock / reset ----------------
  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  always #5 i_clk = ~i_clk;

  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [3:0]    m_axi_arid, m_axi_arqos, m_axi_arcache;
  logic [1:0]    m_axi_arburst;
  logic [2:0]    m_axi_arsize, m_axi_arprot;
  logic          m_axi_arlock;
  logic          m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic [3:0]    m_axi_rid;
  logic          i_rd_buff_req_en, i_rd_buff_rden;
  logic [7:0]    i_rd_buff_burst_len;
  logic [AW-1:0] i_rd_buff_addr;
  logic          o_rd_cmd_ready, o_rd_buff_vld, o_rd_buff_data_last;
  logic [DW-1:0] o_rd_buff_data;
  logic          o_rd_cmd_fifo_err, o_rd_resp_err;
  logic [2:0]    o_dbg_state;
  logic [9:0]    o_dbg_inflight;
  logic [2:0]    o_dbg_outstanding;

  video_rd_buffer dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arid(m_axi_arid), .m_axi_arburst(m_axi_arburst), .m_axi_arsize(m_axi_arsize),
    .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .i_rd_buff_req_en(i_rd_buff_req_en), .i_rd_buff_burst_len(i_rd_buff_burst_len),
    .i_rd_buff_addr(i_rd_buff_addr), .o_rd_cmd_ready(o_rd_cmd_ready),
    .o_rd_buff_vld(o_rd_buff_vld), .o_rd_buff_data(o_rd_buff_data),
    .o_rd_buff_data_last(o_rd_buff_data_last), .i_rd_buff_rden(i_rd_buff_rden),
    .o_rd_cmd_fifo_err(o_rd_cmd_fifo_err), .o_rd_resp_err(o_rd_resp_err),
    .o_dbg_state(o_dbg_state), .o_dbg_inflight(o_dbg_inflight),
    .o_dbg_outstanding(o_dbg_outstanding)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errs   = 0;
  logic [DW:0]   exp_q[$];    // {last, data} expected from accepted requests
  logic [DW:0]   model_q[$];  // beats delivered to the DUT, not yet popped
  logic [AW+7:0] req_q[$];    // accepted requests {len, addr} awaiting their AR
  logic [AW+7:0] ar_pend[$];  // ARs the slave still owes data for
  int ar_cyc[$];
  int ar_count = 0, rlast_count = 0, beat_count = 0, cyc = 0;
  int first_rlast_cyc = -1;
  int drive_idx = 0, err_beat_idx = -1;
  logic resp_err_model = 1'b0;
  logic rst_seen = 1'b1;
  logic r_go = 1'b0;
  logic [DW:0]   last_pop = '0;
  logic [AW-1:0] last_ar_addr = '0;
  logic [7:0]    last_ar_len = '0;

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] addr, input int beat);
    logic [AW-1:0] b;
    b = AW'(beat);
    return {addr + (b << 4), ~addr, b, addr ^ 32'h5a5a_0000};
  endfunction

  // Model: follows AXI/user events at each edge and checks ARs against requests.
  always @(posedge i_clk) begin : model
    logic [DW:0]   got;
    logic [DW:0]   want;
    logic [AW+7:0] r;
    cyc++;
    rst_seen = i_reset;
    if (i_reset) begin
      model_q.delete(); exp_q.delete(); req_q.delete(); ar_pend.delete(); ar_cyc.delete();
      ar_count = 0; rlast_count = 0; beat_count = 0; first_rlast_cyc = -1;
      resp_err_model = 1'b0;
    end else begin
      if (m_axi_arvalid && m_axi_arready) begin
        chk("ar_has_req", req_q.size() != 0, 1);
        r = (req_q.size() != 0) ? req_q.pop_front() : 'x;
        chk("ar_addr", m_axi_araddr, r[AW-1:0]);
        chk("ar_len", m_axi_arlen, r[AW+7:AW]);
        chk("ar_attrs", {m_axi_arid, m_axi_arburst, m_axi_arsize, m_axi_arprot,
                         m_axi_arqos, m_axi_arlock, m_axi_arcache},
                        {4'd0, 2'b01, 3'd4, 3'd0, 4'd0, 1'b0, 4'd0});
        ar_pend.push_back({m_axi_arlen, m_axi_araddr});
        ar_cyc.push_back(cyc);
        last_ar_addr = m_axi_araddr;
        last_ar_len  = m_axi_arlen;
        ar_count++;
      end
      if (i_rd_buff_rden && model_q.size() > 0) begin
        got  = model_q.pop_front();
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("pop_vs_req", got, want);
        last_pop = got;
      end
      if (m_axi_rvalid) begin
        chk("no_overflow", model_q.size() < DEPTH, 1);
        model_q.push_back({m_axi_rlast, m_axi_rdata});
        beat_count++;
        if (m_axi_rlast) begin
          rlast_count++;
          if (first_rlast_cyc < 0) first_rlast_cyc = cyc;
        end
        if (m_axi_rresp != 2'b00) resp_err_model = 1'b1;
      end
    end
  end

  // Per-cycle compare of user-side outputs, away from the active edge.
  always @(negedge i_clk) begin
    chk("rd_vld", o_rd_buff_vld, model_q.size() > 0);
    if (model_q.size() > 0)
      chk("rd_beat", {o_rd_buff_data_last, o_rd_buff_data}, model_q[0]);
    chk("resp_err", o_rd_resp_err, resp_err_model);
    chk("outstanding", o_dbg_outstanding, ar_count - rlast_count);
  end

  // AXI slave: returns beats for accepted ARs in order while r_go is set.
  initial begin : slave
    logic [AW+7:0] a;
    logic [AW-1:0] r_addr;
    int r_len, r_beat;
    bit r_active;
    r_active = 0; r_addr = '0; r_len = 0; r_beat = 0;
    m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00; m_axi_rid = 4'd0;
    forever begin
      @(posedge i_clk); #2;
      if (rst_seen) begin
        r_active = 0;
        m_axi_rvalid = 1'b0;
      end else begin
        if (m_axi_rvalid) begin
          if (r_beat == r_len) r_active = 0;
          else r_beat++;
        end
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
        if (!r_active && r_go && ar_pend.size() > 0) begin
          a = ar_pend.pop_front();
          r_addr = a[AW-1:0]; r_len = int'(a[AW+7:AW]); r_beat = 0; r_active = 1;
        end
        if (r_active && r_go) begin
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = beat_data(r_addr, r_beat);
          m_axi_rlast  = (r_beat == r_len);
          m_axi_rresp  = (drive_idx == err_beat_idx) ? 2'b10 : 2'b00;
          drive_idx++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_rd_buff_req_en = 1'b0; i_rd_buff_rden = 1'b0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_arvalid"}, m_axi_arvalid, 0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
    chk({tag, "_vld"}, o_rd_buff_vld, 0);
    chk({tag, "_cmd_ready"}, o_rd_cmd_ready, 1);
    chk({tag, "_flags"}, {o_rd_cmd_fifo_err, o_rd_resp_err}, 0);
    chk({tag, "_inflight"}, o_dbg_inflight, 0);
    chk({tag, "_outstanding"}, o_dbg_outstanding, 0);
    chk({tag, "_state"}, o_dbg_state, 3'b001);
  endtask

  task automatic req(input logic [AW-1:0] addr, input logic [7:0] len);
    i_rd_buff_req_en = 1'b1; i_rd_buff_addr = addr; i_rd_buff_burst_len = len;
    if (o_rd_cmd_ready) begin
      req_q.push_back({len, addr});
      for (int i = 0; i <= int'(len); i++)
        exp_q.push_back({i == int'(len), beat_data(addr, i)});
    end
    @(posedge i_clk); #1;
    i_rd_buff_req_en = 1'b0;
  endtask

  task automatic pop_n(input int n, input int budget, input string name);
    int left, t;
    left = n; t = 0;
    while (left > 0 && t < budget) begin
      i_rd_buff_rden = o_rd_buff_vld;
      if (o_rd_buff_vld) left--;
      @(posedge i_clk); #1;
      t++;
    end
    i_rd_buff_rden = 1'b0;
    chk(name, n - left, n);
  endtask

  task automatic wait_ar(input int n, input int budget, input string name);
    int t;
    t = 0;
    while (ar_count < n && t < budget) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk(name, ar_count >= n, 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int t;
    i_rd_buff_req_en = 1'b0; i_rd_buff_rden = 1'b0; i_rd_buff_burst_len = '0;
    i_rd_buff_addr = '0; m_axi_arready = 1'b0;

    // Single burst, with pops attempted on an empty FIFO first.
    do_reset();
    check_reset_state("t1_rst");
    m_axi_arready = 1'b1; r_go = 1'b1;
    i_rd_buff_rden = 1'b1;
    wait_cycles(2);
    i_rd_buff_rden = 1'b0;
    chk("t1_empty_pop_vld", o_rd_buff_vld, 0);
    req(32'h1000, 8'd15);
    pop_n(16, 200, "t1_pops");
    chk("t1_ar_addr", last_ar_addr, 32'h1000);
    chk("t1_ar_len", last_ar_len, 15);
    chk("t1_arsize", m_axi_arsize, 4);
    chk("t1_last_beat", last_pop, {1'b1, beat_data(32'h1000, 15)});
    chk("t1_ar_count", ar_count, 1);
    wait_cycles(2);
    chk("t1_inflight", o_dbg_inflight, 0);
    chk("t1_outstanding", o_dbg_outstanding, 0);
    chk("t1_exp_drained", exp_q.size(), 0);

    // Credit stall: two 256-beat bursts fill the 512-beat FIFO exactly.
    do_reset();
    m_axi_arready = 1'b1; r_go = 1'b1;
    req(32'h2000, 8'd255);
    req(32'h3000, 8'd255);
    req(32'h4000, 8'd255);
    wait_cycles(600);
    chk("t2_ar_count", ar_count, 2);
    chk("t2_fifo_level", model_q.size(), 512);
    chk("t2_inflight", o_dbg_inflight, 0);
    pop_n(255, 400, "t2_pop255");
    wait_cycles(10);
    chk("t2_ar_still2", ar_count, 2);
    pop_n(1, 10, "t2_pop256");
    wait_ar(3, 20, "t2_third_ar");
    pop_n(512, 1500, "t2_drain");
    wait_cycles(2);
    chk("t2_exp_drained", exp_q.size(), 0);

    // Outstanding cap: R held back, six single-beat requests.
    do_reset();
    m_axi_arready = 1'b1; r_go = 1'b0;
    for (int i = 0; i < 6; i++) req(32'h5000 + 32'(i * 64), 8'd0);
    wait_cycles(30);
    chk("t3_ar_cap", ar_count, 4);
    chk("t3_outstanding", o_dbg_outstanding, 4);
    if (ar_cyc.size() > 1) chk("t3_ar_spacing", ar_cyc[1] - ar_cyc[0], 3);
    chk("t3_no_rlast", rlast_count, 0);
    r_go = 1'b1;
    wait_ar(5, 30, "t3_fifth_ar");
    if (ar_cyc.size() > 4) chk("t3_5th_after_rlast", ar_cyc[4] > first_rlast_cyc && first_rlast_cyc > 0, 1);
    pop_n(6, 200, "t3_pops");
    chk("t3_ar_total", ar_count, 6);

    // Command overflow: FSM parked at the outstanding cap, arready low.
    do_reset();
    m_axi_arready = 1'b1; r_go = 1'b0;
    for (int i = 0; i < 4; i++) req(32'h9000 + 32'(i * 64), 8'd0);
    wait_ar(4, 30, "t4_cap");
    m_axi_arready = 1'b0;
    for (int i = 0; i < 16; i++) req(32'hA000 + 32'(i * 64), 8'(i % 4));
    chk("t4_ready_after16", o_rd_cmd_ready, 0);
    chk("t4_no_err_yet", o_rd_cmd_fifo_err, 0);
    req(32'hB000, 8'd3);
    chk("t4_err_17th", o_rd_cmd_fifo_err, 1);
    m_axi_arready = 1'b1; r_go = 1'b1;
    pop_n(44, 800, "t4_pops");
    chk("t4_ar_total", ar_count, 20);
    chk("t4_err_sticky", o_rd_cmd_fifo_err, 1);

    // Error response on the third beat; flag is sticky.
    do_reset();
    m_axi_arready = 1'b1; r_go = 1'b1;
    err_beat_idx = drive_idx + 2;
    req(32'h6000, 8'd3);
    pop_n(4, 100, "t5_pops");
    chk("t5_resp_err", o_rd_resp_err, 1);
    req(32'h6100, 8'd1);
    pop_n(2, 100, "t5_pops2");
    chk("t5_resp_err_sticky", o_rd_resp_err, 1);

    // Reset mid-burst, then a fresh request.
    do_reset();
    check_reset_state("t6_rst_clears");
    m_axi_arready = 1'b1; r_go = 1'b1;
    req(32'h7000, 8'd15);
    t = 0;
    while (beat_count < 5 && t < 50) begin
      @(posedge i_clk); #1;
      t++;
    end
    chk("t6_five_beats", beat_count, 5);
    do_reset();
    check_reset_state("t6_mid_rst");
    req(32'h8000, 8'd7);
    pop_n(8, 100, "t6_pops");
    wait_cycles(2);
    chk("t6_exp_drained", exp_q.size(), 0);
    chk("t6_inflight", o_dbg_inflight, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
